maze_gen_avm_writer: RTL and testbench
======================================

// Module: maze_gen_avm_writer
// PURPOSE
//  Hardware maze generator, upstream of the VGA/game interface. On a new-round request it
//  draws a random 8x6-room wall layout from an LFSR and renders it into 600 words of bitmap.
//  It writes those words through an Avalon-MM master into the interface's slave maze registers,
//  then raises maze_ready and a spawn_pos for the game-state logic.
// PARAMETERS
//  LFSR_SEED   16'hACE1  LFSR reset value; must be nonzero
//  ROOM_PX     20        room pitch in maze cells (1 cell = 4x4 px); 160/ROOM_PX=8 cols, 120/ROOM_PX=6 rows
// PORTS
//  CLK              in   1   50 MHz system clock
//  RESET_N          in   1   asynchronous, active-low reset
//  game_reset       in   2   new-round request; start = rising edge of |game_reset
//  AVM_WAITREQUEST  in   1   slave stall; hold all AVM_* outputs while high
//  AVM_CS           out  1   chip select; equals AVM_WRITE
//  AVM_WRITE        out  1   write strobe
//  AVM_ADDR         out  10  word address 0..599
//  AVM_WRITEDATA    out  32  maze word; bit 31 = leftmost cell
//  AVM_BYTE_EN      out  4   constant 4'hF
//  maze_ready       out  1   maze fully written and stable
//  spawn_pos        out  20  [19:10] tank2 spawn X px, [9:0] tank1 spawn X px
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, lfsr=LFSR_SEED, all AVM_* outputs=0 except
//    AVM_BYTE_EN=4'hF, maze_ready=0, spawn_pos=0, wall regs=0.
//    A reset mid-WRITE aborts the transfer immediately; partial maze stays in the slave.
//  - LFSR: 16-bit Galois, taps mask 16'hB400, advances every cycle in every state.
//    Free-running so that user timing seeds the maze.
//  - FSM states and transitions:
//    IDLE:  maze_ready=0; on start edge go to SEED.
//    SEED:  82 cycles, k=0..81. k<42 loads vwall[r][c] (6x7) = lfsr[0]; k>=42 loads hwall[r][c] (5x8) = lfsr[0].
//           On k=81 latch spawn: t1 col c1=lfsr[1:0], t2 col c2=4+lfsr[3:2]; X px = 80*c+40.
//           Then go to WRITE with addr=0.
//    WRITE: AVM_WRITE=1. A word is accepted on a cycle with AVM_WAITREQUEST=0; addr then increments.
//           Accepting addr 599 goes to DONE.
//    DONE:  maze_ready=1, AVM_WRITE=0; on start edge clear maze_ready and go to SEED.
//  - Start edges seen during SEED/WRITE are ignored; there is no pending latch.
//  - Word render (comb from addr): row y=addr/5, word w=addr%5.
//    Cell x=32w+i, output bit 31-i, i=0..31.
//    Wall if x==0 || x==159 || y==0 || y==119
//     || (x%ROOM_PX==ROOM_PX-1 && x<159 && vwall[y/ROOM_PX][x/ROOM_PX])
//     || (y%ROOM_PX==ROOM_PX-1 && y<119 && hwall[y/ROOM_PX][x/ROOM_PX]).
//  - Divides by 5 and ROOM_PX are done with row/col counters tracked alongside addr, not dividers.
//  - Latency with no stalls: maze_ready rises 682 cycles after the start edge is sampled.
//    Each stall cycle adds 1.
// CONFIGURATION
//  MAZE_GEN_WALL_COUNT_EN defined:
//   Adds output wall_count[6:0], the popcount of vwall+hwall latched at end of SEED; reset 0.
//  MAZE_GEN_WALL_COUNT_EN undefined:
//   The port and the popcount logic are absent.
// STRUCTURE
//  maze_pkg: MAZE_WORDS=600, WORDS_PER_ROW=5, MAZE_W=160, MAZE_H=120, LFSR_TAPS=16'hB400,
//   typedef enum {IDLE,SEED,WRITE,DONE} maze_gen_state_t.
//  Sub-module maze_lfsr16: clk, rst_n, q[15:0]; free-running Galois LFSR.
// TESTING
//  1. Reset, start, no stalls -> 600 writes, addr 0..599 in order.
//     maze_ready=1 exactly 682 cycles after the edge.
//  2. Any layout -> words 0..4 and 595..599 = 32'hFFFFFFFF.
//     Row 1: word 0 bit 31=1, word 4 bit 0=1.
//  3. Force all vwall=1, hwall=0 -> row 1 word 0 = 32'h80001000 (x=0, x=19).
//  4. AVM_WAITREQUEST high 3 cycles at addr 100 -> addr/data held stable.
//     No skip or duplicate; maze_ready delayed by 3.
//  5. RESET_N low at addr 300 -> outputs 0 asynchronously; IDLE.
//     Next start rewrites from addr 0.
//  6. Start edge during WRITE -> ignored. Start edge in DONE -> maze_ready falls next cycle;
//     spawn_pos in {40,120,200,280} (t1) and {360,440,520,600} (t2).

Source files
------------

// File: rtl/maze_pkg.sv
// Shared constants and state type for the maze generator.
// Contents: maze geometry, Avalon word count, LFSR taps, FSM state enum.
package maze_pkg;

  localparam int unsigned MAZE_WORDS    = 600;
  localparam int unsigned WORDS_PER_ROW = 5;
  localparam int unsigned MAZE_W        = 160;
  localparam int unsigned MAZE_H        = 120;
  localparam int unsigned ADDR_W        = 10;
  localparam int unsigned DATA_W        = 32;
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEED  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } maze_gen_state_t;

endpackage

// File: rtl/maze_lfsr16.sv
// Free-running 16-bit Galois LFSR; advances every cycle out of reset.
// Ports: clk, rst_n (async active-low), q[15:0] current LFSR state.
module maze_lfsr16
  import maze_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= SEED;
    else        q <= q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
  end

endmodule

// File: rtl/maze_gen_avm_writer.sv
// Maze generator: on a new-round request it samples 82 wall bits from a free-running
// LFSR, renders the 160x120-cell bitmap as 600 words and writes them over Avalon-MM,
// then raises maze_ready with tank spawn columns.
// Ports: CLK, RESET_N (async active-low), game_reset (start on rising |game_reset),
//   AVM_WAITREQUEST, AVM_CS/AVM_WRITE/AVM_ADDR/AVM_WRITEDATA/AVM_BYTE_EN master outputs,
//   maze_ready, spawn_pos {t2 X, t1 X}.
// Option: MAZE_GEN_WALL_COUNT_EN adds wall_count, popcount of the drawn walls.
module maze_gen_avm_writer
  import maze_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned ROOM_PX   = 20
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [1:0]        game_reset,
  input  logic              AVM_WAITREQUEST,
  output logic              AVM_CS,
  output logic              AVM_WRITE,
  output logic [ADDR_W-1:0] AVM_ADDR,
  output logic [DATA_W-1:0] AVM_WRITEDATA,
  output logic [3:0]        AVM_BYTE_EN,
  output logic              maze_ready,
  output logic [19:0]       spawn_pos
`ifdef MAZE_GEN_WALL_COUNT_EN
  ,
  output logic [6:0]        wall_count
`endif
);

  localparam int unsigned N_COLS      = MAZE_W / ROOM_PX;
  localparam int unsigned N_ROWS      = MAZE_H / ROOM_PX;
  localparam int unsigned V_BITS      = N_ROWS * (N_COLS - 1);
  localparam int unsigned H_BITS      = (N_ROWS - 1) * N_COLS;
  localparam int unsigned SEED_CYCLES = V_BITS + H_BITS;
  localparam int unsigned LAST_ADDR   = MAZE_WORDS - 1;

  maze_gen_state_t state_q, state_d;

  logic [15:0] lfsr;
  logic [11:0] lfsr_unused;
  logic        gr_q, start_c, accept_c, seed_last_c, addr_last_c;

  logic [6:0]             seed_q, seed_d;
  logic [SEED_CYCLES-1:0] walls_q, walls_d;
  logic [2:0]             w_q, w_d, ry_q, ry_d;
  logic [6:0]             y_q, y_d;
  logic [4:0]             yr_q, yr_d;
  logic [ADDR_W-1:0]      addr_d;
  logic                   write_d, ready_d;
  logic [19:0]            spawn_d;
  logic [DATA_W-1:0]      render_word;
  logic [7:0]             vw [8];
  logic [7:0]             hw [8];

  maze_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (CLK),
    .rst_n (RESET_N),
    .q     (lfsr)
  );

  // Only the low nibble feeds the maze; the rest just keeps the sequence long.
  assign lfsr_unused = lfsr[15:4];

  assign start_c     = (|game_reset) & ~gr_q;
  assign accept_c    = AVM_WRITE & ~AVM_WAITREQUEST;
  assign seed_last_c = (seed_q == 7'(SEED_CYCLES - 1));
  assign addr_last_c = (AVM_ADDR == ADDR_W'(LAST_ADDR));
  assign AVM_BYTE_EN = 4'hF;

  // State register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; start edges outside IDLE/DONE are dropped
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_c) state_d = SEED;
      SEED:    if (seed_last_c) state_d = WRITE;
      WRITE:   if (accept_c && addr_last_c) state_d = DONE;
      DONE:    if (start_c) state_d = SEED;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values; row, room-row and word counters shadow the address
  always_comb begin
    seed_d  = seed_q;
    walls_d = walls_q;
    w_d     = w_q;
    y_d     = y_q;
    yr_d    = yr_q;
    ry_d    = ry_q;
    addr_d  = AVM_ADDR;
    write_d = AVM_WRITE;
    ready_d = maze_ready;
    spawn_d = spawn_pos;
    case (state_q)
      IDLE, DONE: begin
        if (start_c) begin
          seed_d  = '0;
          ready_d = 1'b0;
        end
      end
      SEED: begin
        // Bit sampled on seed cycle k lands at walls[k] after the last shift
        walls_d = {lfsr[0], walls_q[SEED_CYCLES-1:1]};
        seed_d  = seed_q + 7'd1;
        if (seed_last_c) begin
          spawn_d = {10'd80 * {8'd0, lfsr[3:2]} + 10'd360,
                     10'd80 * {8'd0, lfsr[1:0]} + 10'd40};
          w_d     = '0;
          y_d     = '0;
          yr_d    = '0;
          ry_d    = '0;
          addr_d  = '0;
          write_d = 1'b1;
        end
      end
      WRITE: begin
        if (accept_c) begin
          if (addr_last_c) begin
            write_d = 1'b0;
            ready_d = 1'b1;
          end else begin
            addr_d = AVM_ADDR + ADDR_W'(1);
            if (w_q == 3'(WORDS_PER_ROW - 1)) begin
              w_d = '0;
              y_d = y_q + 7'd1;
              if (yr_q == 5'(ROOM_PX - 1)) begin
                yr_d = '0;
                ry_d = ry_q + 3'd1;
              end else begin
                yr_d = yr_q + 5'd1;
              end
            end else begin
              w_d = w_q + 3'd1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Room wall tables; padded entries stay zero so any 3-bit index is safe
  always_comb begin
    for (int unsigned r = 0; r < 8; r++) begin
      vw[r] = '0;
      hw[r] = '0;
      for (int unsigned c = 0; c < 8; c++) begin
        if (r < N_ROWS && c < N_COLS - 1)
          vw[r][3'(c)] = walls_q[7'(r * (N_COLS - 1) + c)];
        if (r < N_ROWS - 1 && c < N_COLS)
          hw[r][3'(c)] = walls_q[7'(V_BITS + r * N_COLS + c)];
      end
    end
  end

  function automatic logic wall_bit(input int unsigned x, input logic [6:0] y,
                                    input logic [4:0] yr, input logic [7:0] vrow,
                                    input logic [7:0] hrow);
    logic border, vert, horz;
    border = (x == 0) || (x == MAZE_W - 1) || (y == 7'd0) || (y == 7'(MAZE_H - 1));
    vert   = (x % ROOM_PX == ROOM_PX - 1) && (x < MAZE_W - 1) && vrow[3'(x / ROOM_PX)];
    horz   = (yr == 5'(ROOM_PX - 1)) && (y < 7'(MAZE_H - 1)) && hrow[3'(x / ROOM_PX)];
    return border || vert || horz;
  endfunction

  // Word for the address about to be presented; x is a constant per unrolled bit
  always_comb begin
    render_word = '0;
    for (int unsigned wi = 0; wi < WORDS_PER_ROW; wi++) begin
      if (w_d == 3'(wi)) begin
        for (int unsigned i = 0; i < DATA_W; i++)
          render_word[5'(DATA_W - 1 - i)] = wall_bit(DATA_W * wi + i, y_d, yr_d,
                                                     vw[ry_d], hw[ry_d]);
      end
    end
  end

  // Datapath registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      gr_q          <= 1'b0;
      seed_q        <= '0;
      walls_q       <= '0;
      w_q           <= '0;
      y_q           <= '0;
      yr_q          <= '0;
      ry_q          <= '0;
      AVM_ADDR      <= '0;
      AVM_WRITE     <= 1'b0;
      AVM_CS        <= 1'b0;
      AVM_WRITEDATA <= '0;
      maze_ready    <= 1'b0;
      spawn_pos     <= '0;
    end else begin
      gr_q       <= |game_reset;
      seed_q     <= seed_d;
      walls_q    <= walls_d;
      w_q        <= w_d;
      y_q        <= y_d;
      yr_q       <= yr_d;
      ry_q       <= ry_d;
      AVM_ADDR   <= addr_d;
      AVM_WRITE  <= write_d;
      AVM_CS     <= write_d;
      maze_ready <= ready_d;
      spawn_pos  <= spawn_d;
      if (write_d) AVM_WRITEDATA <= render_word;
    end
  end

`ifdef MAZE_GEN_WALL_COUNT_EN
  // Wall popcount captured together with the final seed bit
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                          wall_count <= '0;
    else if (state_q == SEED && seed_last_c) wall_count <= 7'($countones(walls_d));
  end
`endif

endmodule

// File: tb/tb_maze_gen_avm_writer.sv
// Self-checking bench for maze_gen_avm_writer: reference maze model + write scoreboard.
module tb_maze_gen_avm_writer;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [1:0]  game_reset = 2'b00;
  logic        AVM_WAITREQUEST = 1'b0;
  logic        AVM_CS, AVM_WRITE, maze_ready;
  logic [9:0]  AVM_ADDR;
  logic [31:0] AVM_WRITEDATA;
  logic [3:0]  AVM_BYTE_EN;
  logic [19:0] spawn_pos;
`ifdef MAZE_GEN_WALL_COUNT_EN
  logic [6:0]  wall_count;
`endif

  always #5 CLK = ~CLK;

  maze_gen_avm_writer dut (
    .CLK             (CLK),
    .RESET_N         (RESET_N),
    .game_reset      (game_reset),
    .AVM_WAITREQUEST (AVM_WAITREQUEST),
    .AVM_CS          (AVM_CS),
    .AVM_WRITE       (AVM_WRITE),
    .AVM_ADDR        (AVM_ADDR),
    .AVM_WRITEDATA   (AVM_WRITEDATA),
    .AVM_BYTE_EN     (AVM_BYTE_EN),
    .maze_ready      (maze_ready),
    .spawn_pos       (spawn_pos)
`ifdef MAZE_GEN_WALL_COUNT_EN
    ,
    .wall_count      (wall_count)
`endif
  );

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t0_cyc  = 0;
  int stall_cnt = 0;

  logic [15:0] m_lfsr;
  logic        m_v [6][7];
  logic        m_h [5][8];
  logic [9:0]  m_t1, m_t2;
  int          m_walls;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  // Reference LFSR: reset to seed, one step per clock
  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) m_lfsr <= 16'hACE1;
    else          m_lfsr <= lfsr_step(m_lfsr);
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Walls drawn from the LFSR value held just before the start edge
  task automatic build_model(input logic [15:0] l0);
    logic [15:0] l;
    l = l0;
    m_walls = 0;
    for (int k = 0; k < 82; k++) begin
      l = lfsr_step(l);
      if (k < 42) m_v[k / 7][k % 7] = l[0];
      else        m_h[(k - 42) / 8][(k - 42) % 8] = l[0];
      if (l[0]) m_walls++;
    end
    m_t1 = 10'(80 * int'(l[1:0]) + 40);
    m_t2 = 10'(80 * (4 + int'(l[3:2])) + 40);
  endtask

  function automatic logic [31:0] exp_word(input int a);
    int y, w, x;
    logic [31:0] r;
    y = a / 5;
    w = a % 5;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      x = 32 * w + i;
      r[31 - i] = (x == 0) || (x == 159) || (y == 0) || (y == 119);
      if (x % 20 == 19 && x < 159) begin
        if (m_v[y / 20][x / 20]) r[31 - i] = 1'b1;
      end
      if (y % 20 == 19 && y < 119) begin
        if (m_h[y / 20][x / 20]) r[31 - i] = 1'b1;
      end
    end
    return r;
  endfunction

  // Monitor: stall stability plus in-order scoreboard of accepted writes
  logic        prev_stall = 1'b0;
  logic [9:0]  prev_a;
  logic [31:0] prev_d;
  always @(negedge CLK) begin
    exp_t e;
    if (RESET_N && AVM_WRITE) begin
      if (prev_stall) begin
        check("stall_hold_addr", 32'(AVM_ADDR), 32'(prev_a));
        check("stall_hold_data", AVM_WRITEDATA, prev_d);
      end
      if (AVM_WAITREQUEST) begin
        stall_cnt++;
      end else if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0d with nothing expected", AVM_ADDR);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(AVM_ADDR), 32'(e.a));
        check("wr_data", AVM_WRITEDATA, e.d);
        if (AVM_CS !== 1'b1 || AVM_BYTE_EN !== 4'hF)
          check("wr_cs_be", {27'd0, AVM_CS, AVM_BYTE_EN}, {27'd0, 1'b1, 4'hF});
      end
      prev_stall = AVM_WAITREQUEST;
      prev_a     = AVM_ADDR;
      prev_d     = AVM_WRITEDATA;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_write"}, 32'(AVM_WRITE), 32'd0);
    check({tag, "_cs"}, 32'(AVM_CS), 32'd0);
    check({tag, "_addr"}, 32'(AVM_ADDR), 32'd0);
    check({tag, "_data"}, AVM_WRITEDATA, 32'd0);
    check({tag, "_byte_en"}, 32'(AVM_BYTE_EN), 32'hF);
    check({tag, "_ready"}, 32'(maze_ready), 32'd0);
    check({tag, "_spawn"}, 32'(spawn_pos), 32'd0);
  endtask

  // Issue a start edge and queue the full expected maze
  task automatic start_round(input bit from_done);
    @(posedge CLK); #1;
    game_reset      = 2'b00;
    AVM_WAITREQUEST = 1'b0;
    repeat ($urandom_range(1, 8)) begin @(posedge CLK); #1; end
    game_reset = 2'($urandom_range(1, 3));
    build_model(m_lfsr);
    for (int a = 0; a < 600; a++) exp_q.push_back('{a: 10'(a), d: exp_word(a)});
    stall_cnt = 0;
    @(posedge CLK); #1;
    t0_cyc = cyc;
    if (from_done) check("ready_fall_on_start", 32'(maze_ready), 32'd0);
  endtask

  // mode 0: no stalls, ignored start edges; 1: 3-cycle stall at addr 100; 2: random stalls
  task automatic wait_done(input int mode, output int lat);
    int stall_left;
    bit stalled;
    stall_left = 0;
    stalled    = 0;
    lat        = -1;
    for (int it = 0; it < 4000; it++) begin
      @(posedge CLK); #1;
      if (maze_ready) begin
        lat = cyc - t0_cyc;
        break;
      end
      case (mode)
        0: begin
          if (it == 10 || it == 150) game_reset = 2'b00;
          if (it == 12)  game_reset = 2'b10;
          if (it == 153) game_reset = 2'b11;
        end
        1: begin
          if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) AVM_WAITREQUEST = 1'b0;
          end else if (!stalled && AVM_WRITE && AVM_ADDR == 10'd100) begin
            stalled         = 1;
            stall_left      = 3;
            AVM_WAITREQUEST = 1'b1;
          end
        end
        default: AVM_WAITREQUEST = ($urandom_range(0, 3) == 0);
      endcase
    end
    AVM_WAITREQUEST = 1'b0;
    if (lat < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout: maze_ready never rose");
    end
  endtask

  task automatic check_done(input int lat, input int exp_lat);
    check("latency", 32'(lat), 32'(exp_lat));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("spawn_t1", 32'(spawn_pos[9:0]), 32'(m_t1));
    check("spawn_t2", 32'(spawn_pos[19:10]), 32'(m_t2));
    check("spawn_t1_set", 32'(spawn_pos[9:0] inside {10'd40, 10'd120, 10'd200, 10'd280}), 32'd1);
    check("spawn_t2_set", 32'(spawn_pos[19:10] inside {10'd360, 10'd440, 10'd520, 10'd600}), 32'd1);
    check("write_low_done", 32'(AVM_WRITE), 32'd0);
`ifdef MAZE_GEN_WALL_COUNT_EN
    check("wall_count", 32'(wall_count), 32'(m_walls));
`endif
  endtask

  initial begin
    int lat;
    bit found;
    #12;
    check_reset_outputs("por");
    #15;
    RESET_N = 1'b1;

    // Plain round with start edges during SEED and WRITE that must be ignored
    start_round(1'b0);
    wait_done(0, lat);
    check_done(lat, 682);

    // Restart from DONE with a 3-cycle stall at address 100
    start_round(1'b1);
    wait_done(1, lat);
    check_done(lat, 685);
    check("stall_cycles", 32'(stall_cnt), 32'd3);

    // Restart from DONE with random stalls
    start_round(1'b1);
    wait_done(2, lat);
    check_done(lat, 682 + stall_cnt);

    // Abort mid-transfer with an asynchronous reset
    start_round(1'b1);
    found = 0;
    for (int it = 0; it < 2000; it++) begin
      @(posedge CLK); #1;
      if (AVM_WRITE && AVM_ADDR == 10'd300) begin
        found = 1;
        break;
      end
    end
    check("reached_addr_300", 32'(found), 32'd1);
    #2;
    RESET_N    = 1'b0;
    game_reset = 2'b00;
    #1;
    check_reset_outputs("async_rst");
    exp_q.delete();
    @(negedge CLK); #2;
    RESET_N = 1'b1;
    repeat (5) begin @(posedge CLK); #1; end
    check("idle_after_rst_write", 32'(AVM_WRITE), 32'd0);
    check("idle_after_rst_ready", 32'(maze_ready), 32'd0);

    // Fresh round after the abort starts again from address 0
    start_round(1'b0);
    wait_done(0, lat);
    check_done(lat, 682);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
